wb_regfile: RTL and testbench

Register file with write-back bypass and a per-register pending-write scoreboard, sitting at the decode end of the write-back path. It accepts the write-back stage's result (data, destination, enable) each cycle. It serves two combinational read ports to decode, forwarding same-cycle write data, and tracks which registers still have an in-flight producer so decode can stall.

---
 rtl/wb_regfile.sv | 81 ++++++++
 tb/tb_wb_regfile.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/wb_regfile.sv
// Register file with write-back bypass and a per-register pending-write scoreboard.
// Reads, busy and err are combinational; regs and busy update on the rising edge.
module wb_regfile #(
  parameter int W = 16,
  parameter int N = 8,
  parameter int S = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] writeData,
  input  logic [S-1:0] writeRegSel,
  input  logic         write,
  input  logic [S-1:0] read1RegSel,
  input  logic [S-1:0] read2RegSel,
  input  logic [S-1:0] issueRegSel,
  input  logic         issue,
  output logic [W-1:0] read1Data,
  output logic [W-1:0] read2Data,
  output logic         read1Busy,
  output logic         read2Busy,
  output logic         err
);

  logic [W-1:0] regs_q [N];
  logic [W-1:0] regs_d [N];
  logic [N-1:0] busy_q;
  logic [N-1:0] busy_d;

  logic hit1;
  logic hit2;
  logic hit_issue;

  assign hit1      = write && (writeRegSel == read1RegSel);
  assign hit2      = write && (writeRegSel == read2RegSel);
  assign hit_issue = write && (writeRegSel == issueRegSel);

  always_comb begin
    regs_d = regs_q;
    busy_d = busy_q;
    if (write) begin
      regs_d[writeRegSel] = writeData;
    end
    // A new producer supersedes the completing one, so set wins over clear.
    for (int r = 0; r < N; r++) begin
      if (issue && (issueRegSel == S'(r))) begin
        busy_d[r] = 1'b1;
      end else if (write && (writeRegSel == S'(r))) begin
        busy_d[r] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < N; r++) begin
        regs_q[r] <= '0;
      end
      busy_q <= '0;
    end else begin
      regs_q <= regs_d;
      busy_q <= busy_d;
    end
  end

  always_comb begin
    read1Data = '0;
    read2Data = '0;
    read1Busy = 1'b0;
    read2Busy = 1'b0;
    err       = 1'b0;
    if (!rst) begin
      read1Data = hit1 ? writeData : regs_q[read1RegSel];
      read2Data = hit2 ? writeData : regs_q[read2RegSel];
      // The completing producer's register reads as ready, with bypassed data.
      read1Busy = busy_q[read1RegSel] && !hit1;
      read2Busy = busy_q[read2RegSel] && !hit2;
      err       = issue && busy_q[issueRegSel] && !hit_issue;
    end
  end

endmodule

// File: tb/tb_wb_regfile.sv
// Bench for wb_regfile: per-cycle vector table plus hand sequences, checked via an expectation queue.
module tb_wb_regfile;

  logic        clk;
  logic        rst;
  logic [15:0] writeData;
  logic [2:0]  writeRegSel;
  logic        write;
  logic [2:0]  read1RegSel;
  logic [2:0]  read2RegSel;
  logic [2:0]  issueRegSel;
  logic        issue;
  logic [15:0] read1Data;
  logic [15:0] read2Data;
  logic        read1Busy;
  logic        read2Busy;
  logic        err;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        rst;
    logic        wr;
    logic [2:0]  wsel;
    logic [15:0] wdat;
    logic [2:0]  r1;
    logic [2:0]  r2;
    logic        iss;
    logic [2:0]  isel;
    logic [15:0] d1;
    logic [15:0] d2;
    logic        b1;
    logic        b2;
    logic        er;
  } vec_t;

  typedef struct {
    int          id;
    logic [15:0] d1;
    logic [15:0] d2;
    logic        b1;
    logic        b2;
    logic        er;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];
  int   row = 0;

  wb_regfile #(.W(16), .N(8), .S(3)) dut (
    .clk        (clk),
    .rst        (rst),
    .writeData  (writeData),
    .writeRegSel(writeRegSel),
    .write      (write),
    .read1RegSel(read1RegSel),
    .read2RegSel(read2RegSel),
    .issueRegSel(issueRegSel),
    .issue      (issue),
    .read1Data  (read1Data),
    .read2Data  (read2Data),
    .read1Busy  (read1Busy),
    .read2Busy  (read2Busy),
    .err        (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mk(input logic rs, input logic wr, input logic [2:0] wsel,
                              input logic [15:0] wdat, input logic [2:0] r1, input logic [2:0] r2,
                              input logic iss, input logic [2:0] isel, input logic [15:0] d1,
                              input logic [15:0] d2, input logic b1, input logic b2, input logic er);
    vec_t v;
    v.rst = rs; v.wr = wr; v.wsel = wsel; v.wdat = wdat; v.r1 = r1; v.r2 = r2;
    v.iss = iss; v.isel = isel; v.d1 = d1; v.d2 = d2; v.b1 = b1; v.b2 = b2; v.er = er;
    return v;
  endfunction

  task automatic chk(input string name, input int id, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s row %0d: got %h expected %h", name, id, act, exp);
    end
  endtask

  // Drive one cycle's inputs, queue the expectation, compare on the falling edge.
  task automatic run_vec(input vec_t v);
    exp_t e;
    exp_t got;
    @(posedge clk);
    #1;
    rst = v.rst; write = v.wr; writeRegSel = v.wsel; writeData = v.wdat;
    read1RegSel = v.r1; read2RegSel = v.r2; issue = v.iss; issueRegSel = v.isel;
    e.id = row; e.d1 = v.d1; e.d2 = v.d2; e.b1 = v.b1; e.b2 = v.b2; e.er = v.er;
    sb.push_back(e);
    row++;
    @(negedge clk);
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard_empty row %0d: got 0 entries expected 1", row);
    end else begin
      got = sb.pop_front();
      chk("read1Data", got.id, read1Data, got.d1);
      chk("read2Data", got.id, read2Data, got.d2);
      chk("read1Busy", got.id, 16'(read1Busy), 16'(got.b1));
      chk("read2Busy", got.id, 16'(read2Busy), 16'(got.b2));
      chk("err", got.id, 16'(err), 16'(got.er));
    end
  endtask

  initial begin
    rst = 1'b1; write = 1'b0; writeRegSel = '0; writeData = '0;
    read1RegSel = '0; read2RegSel = '0; issue = 1'b0; issueRegSel = '0;

    //          rst  wr  wsel  wdat      r1    r2    iss isel   d1        d2       b1 b2 er
    // Reset for two cycles: outputs forced low, write/issue ignored.
    vecs.push_back(mk(1'b1,1'b1,3'd2,16'hFFFF,3'd2,3'd2,1'b1,3'd2,16'h0000,16'h0000,1'b0,1'b0,1'b0));
    vecs.push_back(mk(1'b1,1'b0,3'd0,16'h0000,3'd0,3'd1,1'b0,3'd0,16'h0000,16'h0000,1'b0,1'b0,1'b0));
    for (int i = 0; i < 8; i++) begin
      vecs.push_back(mk(1'b0,1'b0,3'd0,16'h0000,3'(i),3'(7-i),1'b0,3'd0,16'h0000,16'h0000,1'b0,1'b0,1'b0));
    end
    // Write and bypass.
    vecs.push_back(mk(1'b0,1'b1,3'd3,16'hBEEF,3'd3,3'd4,1'b0,3'd0,16'hBEEF,16'h0000,1'b0,1'b0,1'b0));
    vecs.push_back(mk(1'b0,1'b0,3'd0,16'h0000,3'd3,3'd4,1'b0,3'd0,16'hBEEF,16'h0000,1'b0,1'b0,1'b0));
    // Scoreboard lifecycle on register 5.
    vecs.push_back(mk(1'b0,1'b0,3'd0,16'h0000,3'd5,3'd5,1'b1,3'd5,16'h0000,16'h0000,1'b0,1'b0,1'b0));
    vecs.push_back(mk(1'b0,1'b0,3'd0,16'h0000,3'd5,3'd3,1'b0,3'd0,16'h0000,16'hBEEF,1'b1,1'b0,1'b0));
    vecs.push_back(mk(1'b0,1'b0,3'd0,16'h0000,3'd5,3'd3,1'b0,3'd0,16'h0000,16'hBEEF,1'b1,1'b0,1'b0));
    vecs.push_back(mk(1'b0,1'b1,3'd5,16'h1234,3'd5,3'd5,1'b0,3'd0,16'h1234,16'h1234,1'b0,1'b0,1'b0));
    vecs.push_back(mk(1'b0,1'b0,3'd0,16'h0000,3'd5,3'd3,1'b0,3'd0,16'h1234,16'hBEEF,1'b0,1'b0,1'b0));
    // Set beats clear on register 2.
    vecs.push_back(mk(1'b0,1'b0,3'd0,16'h0000,3'd2,3'd2,1'b1,3'd2,16'h0000,16'h0000,1'b0,1'b0,1'b0));
    vecs.push_back(mk(1'b0,1'b1,3'd2,16'h00AA,3'd2,3'd0,1'b1,3'd2,16'h00AA,16'h0000,1'b0,1'b0,1'b0));
    vecs.push_back(mk(1'b0,1'b0,3'd0,16'h0000,3'd2,3'd5,1'b0,3'd0,16'h00AA,16'h1234,1'b1,1'b0,1'b0));
    // WAW on register 6.
    vecs.push_back(mk(1'b0,1'b0,3'd0,16'h0000,3'd6,3'd2,1'b1,3'd6,16'h0000,16'h00AA,1'b0,1'b1,1'b0));
    vecs.push_back(mk(1'b0,1'b0,3'd0,16'h0000,3'd6,3'd2,1'b1,3'd6,16'h0000,16'h00AA,1'b1,1'b1,1'b1));
    vecs.push_back(mk(1'b0,1'b0,3'd0,16'h0000,3'd6,3'd6,1'b0,3'd0,16'h0000,16'h0000,1'b1,1'b1,1'b0));
    // Simultaneous write and issue to different registers; register 0 is ordinary.
    vecs.push_back(mk(1'b0,1'b1,3'd4,16'h4444,3'd4,3'd7,1'b1,3'd7,16'h4444,16'h0000,1'b0,1'b0,1'b0));
    vecs.push_back(mk(1'b0,1'b1,3'd1,16'h5555,3'd1,3'd7,1'b1,3'd1,16'h5555,16'h0000,1'b0,1'b1,1'b0));
    vecs.push_back(mk(1'b0,1'b1,3'd0,16'hA0A0,3'd0,3'd1,1'b0,3'd0,16'hA0A0,16'h5555,1'b0,1'b1,1'b0));
    vecs.push_back(mk(1'b0,1'b0,3'd0,16'h0000,3'd0,3'd4,1'b0,3'd0,16'hA0A0,16'h4444,1'b0,1'b0,1'b0));

    foreach (vecs[i]) run_vec(vecs[i]);

    // Reset mid-stream: busy[1], busy[7] set, regs[1]=0x5555; the concurrent write is dropped.
    run_vec(mk(1'b0,1'b0,3'd0,16'h0000,3'd1,3'd7,1'b0,3'd0,16'h5555,16'h0000,1'b1,1'b1,1'b0));
    run_vec(mk(1'b1,1'b1,3'd1,16'h9999,3'd1,3'd7,1'b0,3'd0,16'h0000,16'h0000,1'b0,1'b0,1'b0));
    run_vec(mk(1'b0,1'b0,3'd0,16'h0000,3'd1,3'd7,1'b0,3'd0,16'h0000,16'h0000,1'b0,1'b0,1'b0));
    run_vec(mk(1'b0,1'b0,3'd0,16'h0000,3'd2,3'd6,1'b0,3'd0,16'h0000,16'h0000,1'b0,1'b0,1'b0));
    run_vec(mk(1'b0,1'b0,3'd0,16'h0000,3'd3,3'd0,1'b0,3'd0,16'h0000,16'h0000,1'b0,1'b0,1'b0));
    // Issue after reset no longer sees a stale mark, so no WAW.
    run_vec(mk(1'b0,1'b0,3'd0,16'h0000,3'd2,3'd6,1'b1,3'd6,16'h0000,16'h0000,1'b0,1'b0,1'b0));
    // Late write-back from a pre-reset producer updates regs and clears the new mark.
    run_vec(mk(1'b0,1'b1,3'd6,16'h7777,3'd6,3'd1,1'b0,3'd0,16'h7777,16'h0000,1'b0,1'b0,1'b0));
    run_vec(mk(1'b0,1'b0,3'd0,16'h0000,3'd6,3'd6,1'b0,3'd0,16'h7777,16'h7777,1'b0,1'b0,1'b0));

    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard_leftover: got %0d entries expected 0", sb.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
